// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
//   Command responder behind the UART. Parses the host byte stream into
//   byte-wide memory read/write transactions and returns results through
//   the transmitter handshake.
//
//   Protocol (address big-endian, 24 bits on the wire):
//     0x57 A2 A1 A0 D  -> write D to A, reply 0x06
//     0x52 A2 A1 A0 N  -> read N+1 bytes from A upward, reply raw bytes
//   Any other byte received while idle is ignored.
//
//   Optional feature macro: UART_BRIDGE_TIMEOUT_EN
//     defined   : a partial command is abandoned after TIMEOUT clocks without
//                 a received byte while in ADDR/ARG (no reply, no mem access)
//     undefined : ADDR/ARG wait indefinitely
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high
//   rx_data    in   received byte, valid with rx_strobe
//   rx_strobe  in   one-cycle pulse per received byte
//   tx_data    out  byte to transmit, valid with tx_strobe
//   tx_strobe  out  one-cycle send pulse
//   tx_ready   in   transmitter idle
//   mem_addr   out  transaction address (ADDR_WIDTH bits)
//   mem_wdata  out  write data
//   mem_write  out  write request, held until mem_ack
//   mem_read   out  read request, held until mem_ack
//   mem_rdata  in   read data, valid in the mem_ack cycle
//   mem_ack    in   completes the current request
//   busy       out  high in every state except IDLE
//
// States
//   state   | meaning
//   IDLE    | waiting for a command byte (0x57 / 0x52)
//   ADDR    | collecting three address bytes, MSB first
//   ARG     | waiting for write data or read count
//   MEM_WR  | write request outstanding
//   MEM_RD  | read request outstanding
//   TX      | waiting for tx_ready to send the reply byte

module uart_bus_bridge #(
    parameter int ADDR_WIDTH = 24,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_strobe,
    output logic [7:0]            tx_data,
    output logic                  tx_strobe,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);

    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 24 || TIMEOUT < 1) begin : g_bad_params
        $error("uart_bus_bridge: ADDR_WIDTH must be 1..24 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ARG,
        S_MEM_WR,
        S_MEM_RD,
        S_TX
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] WR_ACK    = 8'h06;

    state_t                  state;
    state_t                  state_next;
    logic                    is_write;
    logic [1:0]              addr_bytes;
    logic [23:0]             addr_wire;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [8:0]              remaining;
    logic [7:0]              wdata_q;
    logic [7:0]              tx_byte;
    logic                    mem_write_q;
    logic                    mem_read_q;
    logic                    tx_strobe_q;
    logic                    tx_fire;
    logic                    timeout_hit;

    // Combinational strobe so it can never appear while tx_ready is low;
    // tx_strobe_q keeps two pulses from ever landing on adjacent cycles.
    assign tx_fire = (state == S_TX) && tx_ready && !tx_strobe_q;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT);

    logic [31:0] to_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (rx_strobe || !(state == S_ADDR || state == S_ARG)) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LIMIT) begin
            to_cnt <= to_cnt + 32'd1;
        end
    end

    // A byte arriving in the very cycle the limit is reached still wins.
    assign timeout_hit = (to_cnt == TO_LIMIT) && !rx_strobe;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (rx_strobe && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (timeout_hit) begin
                    state_next = S_IDLE;
                end else if (rx_strobe && addr_bytes == 2'd2) begin
                    state_next = S_ARG;
                end
            end
            S_ARG: begin
                if (timeout_hit) begin
                    state_next = S_IDLE;
                end else if (rx_strobe) begin
                    state_next = is_write ? S_MEM_WR : S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_write_q && mem_ack) begin
                    state_next = S_TX;
                end
            end
            S_MEM_RD: begin
                if (mem_read_q && mem_ack) begin
                    state_next = S_TX;
                end
            end
            S_TX: begin
                if (tx_fire) begin
                    state_next = (is_write || remaining == 9'd1) ? S_IDLE : S_MEM_RD;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_write    <= 1'b0;
            addr_bytes  <= '0;
            addr_wire   <= '0;
            addr_q      <= '0;
            remaining   <= '0;
            wdata_q     <= '0;
            tx_byte     <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            tx_strobe_q <= 1'b0;
        end else begin
            tx_strobe_q <= tx_fire;
            case (state)
                S_IDLE: begin
                    if (rx_strobe) begin
                        is_write   <= (rx_data == CMD_WRITE);
                        addr_bytes <= '0;
                    end
                end
                S_ADDR: begin
                    if (rx_strobe) begin
                        addr_wire  <= {addr_wire[15:0], rx_data};
                        addr_bytes <= addr_bytes + 2'd1;
                    end
                end
                S_ARG: begin
                    if (rx_strobe) begin
                        // Upper wire-address bits beyond ADDR_WIDTH are dropped here.
                        addr_q    <= addr_wire[ADDR_WIDTH-1:0];
                        remaining <= {1'b0, rx_data} + 9'd1;
                        if (is_write) begin
                            wdata_q <= rx_data;
                        end
                    end
                end
                S_MEM_WR: begin
                    if (!mem_write_q) begin
                        mem_write_q <= 1'b1;
                    end else if (mem_ack) begin
                        mem_write_q <= 1'b0;
                        tx_byte     <= WR_ACK;
                    end
                end
                S_MEM_RD: begin
                    if (!mem_read_q) begin
                        mem_read_q <= 1'b1;
                    end else if (mem_ack) begin
                        mem_read_q <= 1'b0;
                        tx_byte    <= mem_rdata;
                    end
                end
                S_TX: begin
                    if (tx_fire && !is_write && remaining != 9'd1) begin
                        remaining <= remaining - 9'd1;
                        addr_q    <= addr_q + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data   = tx_byte;
    assign tx_strobe = tx_fire;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign busy      = (state != S_IDLE);

endmodule
